// File: rtl/quant_int8_nch_pkg.sv
// Shared constants for the multi-channel int8/uint8 requantiser.
package quant_int8_nch_pkg;

    localparam int MODE_PER_CH_BIT = 0;
    localparam int MODE_INT8_BIT   = 1;

    localparam int INT8_MIN  = -128;
    localparam int INT8_MAX  = 127;
    localparam int UINT8_MIN = 0;
    localparam int UINT8_MAX = 255;

    localparam int PIPE_DEPTH = 4;
    localparam int SHIFT_W    = 6;
    localparam int MAX_SHIFT  = 47;

    typedef enum logic [1:0] {
        MODE_UINT8_TENSOR = 2'b00,
        MODE_UINT8_CHAN   = 2'b01,
        MODE_INT8_TENSOR  = 2'b10,
        MODE_INT8_CHAN    = 2'b11
    } quant_mode_e;

endpackage

// File: rtl/quant_int8_nch_if.sv
// Valid/ready stream bundle: accumulator beats in, 8-bit results out.
interface quant_int8_nch_if
    import quant_int8_nch_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int IN_W   = 32
);
    logic [CH_NUM*IN_W-1:0] data_in;
    logic                   in_vld;
    logic                   in_rdy;
    logic [CH_NUM*8-1:0]    data_out;
    logic                   out_vld;
    logic                   out_rdy;

    modport master (
        output data_in, in_vld, out_rdy,
        input  in_rdy, data_out, out_vld
    );

    modport slave (
        input  data_in, in_vld, out_rdy,
        output in_rdy, data_out, out_vld
    );
endinterface

// File: rtl/quant_int8_nch_lane.sv
// One channel of the requantiser datapath: multiply, rounded shift,
// zero-point add and clamp. Stage loads are driven by the top-level control.
module quant_int8_lane
    import quant_int8_nch_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int MULT_W = 15
)(
    input  logic                     sclk,
    input  logic                     s_rst_n,
    input  logic                     ld2,
    input  logic                     ld3,
    input  logic                     ld4,
    input  logic signed [IN_W-1:0]   s1_data,
    input  logic [MULT_W-1:0]        s1_mult,
    input  logic [SHIFT_W-1:0]       s1_shift,
    input  logic [7:0]               s1_zp,
    input  logic                     s1_int8,
    output logic [7:0]               q
);
    localparam int PW = IN_W + MULT_W + 1;
    localparam int YW = PW + 1;
    // The rounding constant can reach 2^46, so the sum needs headroom above that.
    localparam int SW = ((PW > MAX_SHIFT) ? PW : MAX_SHIFT + 1) + 1;

    logic signed [PW-1:0]      prod_c;
    logic signed [PW-1:0]      prod2;
    logic [SHIFT_W-1:0]        shift2;
    logic [7:0]                zp2;
    logic                      int8_2;
    logic signed [SW-1:0]      ext_c;
    logic signed [SW-1:0]      rnd_c;
    logic signed [SW-1:0]      sum_c;
    logic signed [SW-1:0]      shr_c;
    logic signed [PW-1:0]      shifted3;
    logic [7:0]                zp3;
    logic                      int8_3;
    logic signed [YW-1:0]      zp_ext_c;
    logic signed [YW-1:0]      y_c;
    logic [7:0]                q_c;

    assign prod_c = PW'(s1_data) * $signed(PW'({1'b0, s1_mult}));

    // S2: register the signed product and carry the per-beat settings along
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            prod2  <= '0;
            shift2 <= '0;
            zp2    <= '0;
            int8_2 <= 1'b0;
        end else if (ld2) begin
            prod2  <= prod_c;
            shift2 <= s1_shift;
            zp2    <= s1_zp;
            int8_2 <= s1_int8;
        end
    end

    // Round half toward +inf, then arithmetic shift; shift 0 passes the product through
    always_comb begin
        ext_c = SW'(prod2);
        rnd_c = '0;
        if (shift2 != '0) begin
            rnd_c = SW'(1) << (shift2 - SHIFT_W'(1));
        end
        sum_c = ext_c + rnd_c;
        shr_c = sum_c >>> shift2;
    end

    // S3: register the rounded, shifted value
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            shifted3 <= '0;
            zp3      <= '0;
            int8_3   <= 1'b0;
        end else if (ld3) begin
            shifted3 <= PW'(shr_c);
            zp3      <= zp2;
            int8_3   <= int8_2;
        end
    end

    // Zero point is signed in int8 mode and unsigned in uint8 mode; clamp to the output range
    always_comb begin
        if (int8_3) begin
            zp_ext_c = YW'($signed(zp3));
        end else begin
            zp_ext_c = $signed(YW'(zp3));
        end
        y_c = YW'(shifted3) + zp_ext_c;
        q_c = y_c[7:0];
        if (int8_3) begin
            if (y_c > $signed(YW'(INT8_MAX))) begin
                q_c = 8'(INT8_MAX);
            end else if (y_c < $signed(YW'(INT8_MIN))) begin
                q_c = 8'(INT8_MIN);
            end
        end else begin
            if (y_c > $signed(YW'(UINT8_MAX))) begin
                q_c = 8'(UINT8_MAX);
            end else if (y_c < $signed(YW'(UINT8_MIN))) begin
                q_c = 8'(UINT8_MIN);
            end
        end
    end

    // S4: output register, frozen while the downstream stalls
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            q <= '0;
        end else if (ld4) begin
            q <= q_c;
        end
    end

endmodule

// File: rtl/quant_int8_nch.sv
// Multi-channel accumulator requantiser: 4-stage valid/ready pipeline,
// per-channel or per-tensor {mult, shift} table, int8/uint8 output.
module quant_int8_nch
    import quant_int8_nch_pkg::*;
#(
    parameter int CH_NUM = 8,
    parameter int IN_W   = 32,
    parameter int MULT_W = 15
)(
    input  logic                  sclk,
    input  logic                  s_rst_n,
    quant_int8_nch_if.slave       bus,
    input  logic [7:0]            zero_point,
    input  logic [1:0]            mode,
    input  logic                  prm_wr,
    input  logic [4:0]            prm_addr,
    input  logic [MULT_W-1:0]     prm_mult,
    input  logic [SHIFT_W-1:0]    prm_shift
);
    logic [MULT_W-1:0]      mult_tab  [CH_NUM];
    logic [SHIFT_W-1:0]     shift_tab [CH_NUM];
    logic signed [IN_W-1:0] data1     [CH_NUM];
    logic [MULT_W-1:0]      mult1     [CH_NUM];
    logic [SHIFT_W-1:0]     shift1    [CH_NUM];
    logic [7:0]             zp1;
    logic                   int8_1;
    logic                   v1, v2, v3, v4;
    logic                   en1, en2, en3, en4;
    logic [CH_NUM*8-1:0]    data_out_w;

    // A stage may load when it is empty or its content moves on this cycle
    assign en4 = !v4 || bus.out_rdy;
    assign en3 = !v3 || en4;
    assign en2 = !v2 || en3;
    assign en1 = !v1 || en2;

    assign bus.in_rdy   = en1;
    assign bus.out_vld  = v4;
    assign bus.data_out = data_out_w;

    // Parameter table; addresses beyond the last channel match no entry
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                mult_tab[k]  <= '0;
                shift_tab[k] <= '0;
            end
        end else if (prm_wr) begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (prm_addr == 5'(k)) begin
                    mult_tab[k]  <= prm_mult;
                    shift_tab[k] <= prm_shift;
                end
            end
        end
    end

    // Stage-valid flags shift forward as each stage is allowed to load
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            v4 <= 1'b0;
        end else begin
            if (en1) v1 <= bus.in_vld;
            if (en2) v2 <= v1;
            if (en3) v3 <= v2;
            if (en4) v4 <= v3;
        end
    end

    // S1: capture the beat with the table entry and mode it will use for its whole flight
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                data1[k]  <= '0;
                mult1[k]  <= '0;
                shift1[k] <= '0;
            end
            zp1    <= '0;
            int8_1 <= 1'b0;
        end else if (en1 && bus.in_vld) begin
            for (int k = 0; k < CH_NUM; k++) begin
                data1[k]  <= bus.data_in[k*IN_W +: IN_W];
                mult1[k]  <= mode[MODE_PER_CH_BIT] ? mult_tab[k]  : mult_tab[0];
                shift1[k] <= mode[MODE_PER_CH_BIT] ? shift_tab[k] : shift_tab[0];
            end
            zp1    <= zero_point;
            int8_1 <= mode[MODE_INT8_BIT];
        end
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
        quant_int8_lane #(
            .IN_W   (IN_W),
            .MULT_W (MULT_W)
        ) u_lane (
            .sclk     (sclk),
            .s_rst_n  (s_rst_n),
            .ld2      (en2 && v1),
            .ld3      (en3 && v2),
            .ld4      (en4 && v3),
            .s1_data  (data1[k]),
            .s1_mult  (mult1[k]),
            .s1_shift (shift1[k]),
            .s1_zp    (zp1),
            .s1_int8  (int8_1),
            .q        (data_out_w[k*8 +: 8])
        );
    end

endmodule

// File: tb/tb_quant_int8_nch.sv
// Directed self-checking bench for the multi-channel requantiser.
module tb_quant_int8_nch;
    import quant_int8_nch_pkg::*;

    localparam int CH_NUM = 8;
    localparam int IN_W   = 32;
    localparam int MULT_W = 15;
    localparam int OW     = CH_NUM*8;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic [7:0]        zero_point;
    logic [1:0]        mode;
    logic              prm_wr;
    logic [4:0]        prm_addr;
    logic [MULT_W-1:0] prm_mult;
    logic [5:0]        prm_shift;

    int checks = 0;
    int errors = 0;

    quant_int8_nch_if #(.CH_NUM(CH_NUM), .IN_W(IN_W)) bus ();

    quant_int8_nch #(.CH_NUM(CH_NUM), .IN_W(IN_W), .MULT_W(MULT_W)) dut (
        .sclk       (sclk),
        .s_rst_n    (s_rst_n),
        .bus        (bus),
        .zero_point (zero_point),
        .mode       (mode),
        .prm_wr     (prm_wr),
        .prm_addr   (prm_addr),
        .prm_mult   (prm_mult),
        .prm_shift  (prm_shift)
    );

    always #5 sclk = ~sclk;

    task automatic tick;
        @(posedge sclk);
        #1;
    endtask

    task automatic set_all(input logic signed [IN_W-1:0] v);
        for (int k = 0; k < CH_NUM; k++) bus.data_in[k*IN_W +: IN_W] = v;
    endtask

    task automatic set_ch(input int k, input logic signed [IN_W-1:0] v);
        bus.data_in[k*IN_W +: IN_W] = v;
    endtask

    task automatic write_prm(input int addr, input int mult, input int shift);
        prm_wr    = 1'b1;
        prm_addr  = 5'(addr);
        prm_mult  = MULT_W'(mult);
        prm_shift = 6'(shift);
        tick();
        prm_wr    = 1'b0;
    endtask

    // Sends one beat into an empty pipeline and returns the result plus edges until out_vld
    task automatic run_beat(output logic [OW-1:0] obs, output int lat);
        bus.in_vld = 1'b1;
        tick();
        bus.in_vld = 1'b0;
        lat = 0;
        while (!bus.out_vld && lat < 12) begin
            tick();
            lat++;
        end
        obs = bus.out_vld ? bus.data_out : 'x;
        tick();
    endtask

    task automatic test_reset;
        logic [OW-1:0] obs;
        int lat;
        s_rst_n = 1'b1;
        bus.in_vld = 1'b0; bus.out_rdy = 1'b1; set_all(0);
        zero_point = 8'd0; mode = MODE_UINT8_TENSOR;
        prm_wr = 1'b0; prm_addr = '0; prm_mult = '0; prm_shift = '0;
        #1 s_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_vld: got %b expected 0", bus.out_vld); end
        checks++;
        if (bus.data_out !== '0) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0", bus.data_out); end
        tick(); tick();
        s_rst_n = 1'b1;
        tick();
        checks++;
        if (bus.in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_rdy: got %b expected 1", bus.in_rdy); end
        // Table cleared to mult 0: output is just the zero point
        zero_point = 8'd5; set_all(100);
        run_beat(obs, lat);
        checks++;
        if (obs !== {CH_NUM{8'd5}}) begin errors++; $display("[TB] FAIL reset_table: got %h expected %h", obs, {CH_NUM{8'd5}}); end
    endtask

    task automatic test_per_tensor;
        logic [OW-1:0] obs;
        int lat;
        write_prm(0, 16384, 15);
        mode = MODE_UINT8_TENSOR; zero_point = 8'd10; set_all(100);
        run_beat(obs, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL latency: got %0d edges after accept expected 3", lat); end
        checks++;
        if (obs !== {CH_NUM{8'd60}}) begin errors++; $display("[TB] FAIL per_tensor: got %h expected %h", obs, {CH_NUM{8'd60}}); end
        checks++;
        if (bus.out_vld !== 1'b0) begin errors++; $display("[TB] FAIL no_duplicate: got out_vld %b expected 0", bus.out_vld); end
    endtask

    task automatic test_rounding;
        logic [OW-1:0] obs, exp;
        int lat;
        write_prm(0, 1, 1);
        mode = MODE_INT8_TENSOR; zero_point = 8'd0; set_all(0);
        set_ch(0, 3); set_ch(1, -3); set_ch(2, 2); set_ch(3, -2);
        exp = '0; exp[0 +: 8] = 8'h02; exp[8 +: 8] = 8'hFF; exp[16 +: 8] = 8'h01; exp[24 +: 8] = 8'hFF;
        run_beat(obs, lat);
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL round_shift1: got %h expected %h", obs, exp); end
        write_prm(0, 3, 4);
        set_all(0); set_ch(0, 40); set_ch(1, -40); set_ch(2, 8); set_ch(3, -8);
        exp = '0; exp[0 +: 8] = 8'h08; exp[8 +: 8] = 8'hF9; exp[16 +: 8] = 8'h02; exp[24 +: 8] = 8'hFF;
        run_beat(obs, lat);
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL round_shift4: got %h expected %h", obs, exp); end
    endtask

    task automatic test_saturation;
        logic [OW-1:0] obs, exp;
        int lat;
        write_prm(0, 1, 0);
        mode = MODE_UINT8_TENSOR; zero_point = 8'd0; set_all(0);
        set_ch(0, -5); set_ch(1, 300); set_ch(2, 255); set_ch(3, 0); set_ch(4, 7); set_ch(5, 256);
        exp = '0; exp[8 +: 8] = 8'hFF; exp[16 +: 8] = 8'hFF; exp[32 +: 8] = 8'h07; exp[40 +: 8] = 8'hFF;
        run_beat(obs, lat);
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL sat_uint8: got %h expected %h", obs, exp); end
        mode = MODE_INT8_TENSOR;
        set_ch(0, 200); set_ch(1, -200); set_ch(2, 127); set_ch(3, -128);
        set_ch(4, -129); set_ch(5, -7); set_ch(6, 128); set_ch(7, 0);
        exp = {8'h00, 8'h7F, 8'hF9, 8'h80, 8'h80, 8'h7F, 8'h80, 8'h7F};
        run_beat(obs, lat);
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL sat_int8: got %h expected %h", obs, exp); end
        zero_point = 8'hFD; set_all(0);
        set_ch(0, 5); set_ch(1, -126); set_ch(2, 130); set_ch(3, -125);
        exp = {CH_NUM{8'hFD}}; exp[0 +: 8] = 8'h02; exp[8 +: 8] = 8'h80; exp[16 +: 8] = 8'h7F; exp[24 +: 8] = 8'h80;
        run_beat(obs, lat);
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL zp_int8: got %h expected %h", obs, exp); end
        mode = MODE_UINT8_TENSOR; zero_point = 8'd200; set_all(0);
        set_ch(0, 50); set_ch(1, 60); set_ch(2, -100); set_ch(3, -200);
        exp = {CH_NUM{8'hC8}}; exp[0 +: 8] = 8'hFA; exp[8 +: 8] = 8'hFF; exp[16 +: 8] = 8'h64; exp[24 +: 8] = 8'h00;
        run_beat(obs, lat);
        checks++;
        if (obs !== exp) begin errors++; $display("[TB] FAIL zp_uint8: got %h expected %h", obs, exp); end
    endtask

    task automatic test_per_channel;
        logic [OW-1:0] obs, exp_a, exp_b;
        logic [OW-1:0] seq [3];
        int lat, w;
        mode = MODE_UINT8_CHAN; zero_point = 8'd0;
        for (int k = 0; k < CH_NUM; k++) write_prm(k, 1, 0);
        write_prm(8, 5, 3);
        for (int k = 0; k < CH_NUM; k++) set_ch(k, k*3);
        exp_a = '0;
        for (int k = 0; k < CH_NUM; k++) exp_a[k*8 +: 8] = 8'(k*3);
        run_beat(obs, lat);
        checks++;
        if (obs !== exp_a) begin errors++; $display("[TB] FAIL per_channel: got %h expected %h", obs, exp_a); end
        // Beat 0 shares its edge with the entry-2 write, beat 1 follows, beat 2 is per-tensor
        bus.in_vld = 1'b1;
        prm_wr = 1'b1; prm_addr = 5'd2; prm_mult = MULT_W'(2); prm_shift = 6'd0;
        tick();
        prm_wr = 1'b0;
        tick();
        mode = MODE_UINT8_TENSOR;
        tick();
        bus.in_vld = 1'b0;
        mode = MODE_UINT8_CHAN;
        for (int i = 0; i < 3; i++) seq[i] = 'x;
        w = 0;
        while (!bus.out_vld && w < 12) begin tick(); w++; end
        for (int i = 0; i < 3; i++) begin
            if (bus.out_vld) seq[i] = bus.data_out;
            tick();
        end
        exp_b = exp_a; exp_b[16 +: 8] = 8'd12;
        checks++;
        if (seq[0] !== exp_a) begin errors++; $display("[TB] FAIL same_cycle_write_old: got %h expected %h", seq[0], exp_a); end
        checks++;
        if (seq[1] !== exp_b) begin errors++; $display("[TB] FAIL next_beat_new: got %h expected %h", seq[1], exp_b); end
        checks++;
        if (seq[2] !== exp_a) begin errors++; $display("[TB] FAIL per_tensor_entry0: got %h expected %h", seq[2], exp_a); end
    endtask

    task automatic test_back_to_back;
        logic [OW-1:0] seq [3];
        int w;
        write_prm(0, 1, 0);
        mode = MODE_UINT8_TENSOR; zero_point = 8'd5; set_all(10);
        bus.in_vld = 1'b1;
        tick();
        mode = MODE_INT8_TENSOR; zero_point = 8'hF6; set_all(3);
        prm_wr = 1'b1; prm_addr = 5'd0; prm_mult = MULT_W'(2); prm_shift = 6'd0;
        tick();
        prm_wr = 1'b0;
        tick();
        bus.in_vld = 1'b0;
        mode = MODE_UINT8_TENSOR; zero_point = 8'd0;
        for (int i = 0; i < 3; i++) seq[i] = 'x;
        w = 0;
        while (!bus.out_vld && w < 12) begin tick(); w++; end
        for (int i = 0; i < 3; i++) begin
            if (bus.out_vld) seq[i] = bus.data_out;
            tick();
        end
        checks++;
        if (seq[0] !== {CH_NUM{8'h0F}}) begin errors++; $display("[TB] FAIL b2b_beat0: got %h expected %h", seq[0], {CH_NUM{8'h0F}}); end
        checks++;
        if (seq[1] !== {CH_NUM{8'hF9}}) begin errors++; $display("[TB] FAIL b2b_beat1: got %h expected %h", seq[1], {CH_NUM{8'hF9}}); end
        checks++;
        if (seq[2] !== {CH_NUM{8'hFC}}) begin errors++; $display("[TB] FAIL b2b_beat2: got %h expected %h", seq[2], {CH_NUM{8'hFC}}); end
    endtask

    task automatic test_backpressure;
        logic [OW-1:0] exp, prev_data;
        logic prev_stall, exp_rdy, acc, emit, acc_prev;
        int sent, rcvd, cnt, cyc;
        write_prm(0, 1, 0);
        mode = MODE_UINT8_TENSOR; zero_point = 8'd0;
        sent = 0; rcvd = 0; cnt = 0; cyc = 0;
        prev_stall = 1'b0; prev_data = '0; acc_prev = 1'b0;
        bus.in_vld = 1'b0;
        while (rcvd < 20 && cyc < 400) begin
            if (acc_prev) bus.in_vld = 1'b0;
            if (!bus.in_vld && sent < 20 && $urandom_range(0, 3) != 0) begin
                bus.in_vld = 1'b1;
                for (int k = 0; k < CH_NUM; k++) set_ch(k, sent*8 + k);
            end
            bus.out_rdy = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                checks++;
                if (bus.out_vld !== 1'b1 || bus.data_out !== prev_data) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got vld %b data %h expected vld 1 data %h", bus.out_vld, bus.data_out, prev_data);
                end
            end
            exp_rdy = !(cnt == 4 && !bus.out_rdy);
            checks++;
            if (bus.in_rdy !== exp_rdy) begin errors++; $display("[TB] FAIL in_rdy: got %b expected %b (in flight %0d)", bus.in_rdy, exp_rdy, cnt); end
            acc  = bus.in_vld && bus.in_rdy;
            emit = bus.out_vld && bus.out_rdy;
            if (emit) begin
                exp = 'x;
                if (rcvd < 20) for (int k = 0; k < CH_NUM; k++) exp[k*8 +: 8] = 8'(rcvd*8 + k);
                checks++;
                if (bus.data_out !== exp) begin errors++; $display("[TB] FAIL order beat %0d: got %h expected %h", rcvd, bus.data_out, exp); end
                rcvd++;
            end
            prev_stall = bus.out_vld && !bus.out_rdy;
            prev_data  = bus.data_out;
            if (acc) sent++;
            cnt = cnt + (acc ? 1 : 0) - (emit ? 1 : 0);
            acc_prev = acc;
            @(posedge sclk);
            #1;
            cyc++;
        end
        bus.in_vld = 1'b0; bus.out_rdy = 1'b1;
        checks++;
        if (rcvd !== 20) begin errors++; $display("[TB] FAIL stream_count: got %0d beats expected 20", rcvd); end
    endtask

    task automatic test_reset_midstream;
        logic [OW-1:0] obs;
        int lat, seen;
        mode = MODE_UINT8_TENSOR; zero_point = 8'd0; bus.out_rdy = 1'b1;
        bus.in_vld = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_all(i);
            tick();
        end
        bus.in_vld = 1'b0;
        #1 s_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_vld !== 1'b0 || bus.data_out !== '0) begin errors++; $display("[TB] FAIL midstream_reset: got vld %b data %h expected vld 0 data 0", bus.out_vld, bus.data_out); end
        tick(); tick();
        s_rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_vld !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL post_reset_vld: got %0d cycles with out_vld expected 0", seen); end
        write_prm(0, 1, 0);
        set_all(42);
        run_beat(obs, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL post_reset_latency: got %0d expected 3", lat); end
        checks++;
        if (obs !== {CH_NUM{8'd42}}) begin errors++; $display("[TB] FAIL post_reset_data: got %h expected %h", obs, {CH_NUM{8'd42}}); end
    endtask

    initial begin
        test_reset();
        test_per_tensor();
        test_rounding();
        test_saturation();
        test_per_channel();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

endmodule
